subr8u_serial: RTL and testbench

- Bit-serial unsigned subtractor: the inverse operation of the team's 8-bit unsigned adders.
- Computes diff = A - B one bit per cycle, LSB first, through a single one-bit full-subtractor cell.
- Valid/ready handshake on both sides.
- Sits downstream of the adder library: recovers an operand from a sum, or serves as a low-area arithmetic unit in the fault-resilience evaluation harness.

---
 rtl/subr_pkg.sv | 16 +
 rtl/subr8u_serial_fs1u.sv | 13 +
 rtl/subr8u_serial.sv | 130 +++++++++++++
 tb/tb_subr8u_serial.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/subr_pkg.sv
// Shared types and helpers for the bit-serial unsigned subtractor.
package subr_pkg;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} subr_state_e;

    localparam int unsigned SUBR_DEF_WIDTH = 8;

    // Width of a counter that indexes bits 0..n-1 (minimum 1 bit).
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        for (r = 1; (32'd1 << r) < n; r++) begin
        end
        return r;
    endfunction

endpackage

// File: rtl/subr8u_serial_fs1u.sv
// Combinational one-bit full subtractor: d = a - b - bin, bout = borrow out.
module fs1u (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/subr8u_serial.sv
// Bit-serial unsigned subtractor, LSB first, with valid/ready on both sides.
// Define SUBR8U_DMR_EN to add a lockstep duplicate cell and the fault flag.
module subr8u_serial
    import subr_pkg::*;
#(
    parameter int unsigned WIDTH = SUBR_DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             fault
);

    localparam int unsigned CW = clog2(WIDTH);

    subr_state_e      state_q, state_d;
    logic [WIDTH-1:0] a_q, b_q, res_q, diff_q;
    logic [CW-1:0]    cnt_q;
    logic             bin_q, borrow_q;
    logic             d, bout;
    logic             last;

    fs1u u_fs (
        .a    (a_q[0]),
        .b    (b_q[0]),
        .bin  (bin_q),
        .d    (d),
        .bout (bout)
    );

    assign last = (cnt_q == CW'(WIDTH - 1));

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_d = SHIFT;
            end
            SHIFT: begin
                if (last) state_d = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // diff/borrow are separate from the shifting result so they survive the next operation.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            res_q    <= '0;
            diff_q   <= '0;
            cnt_q    <= '0;
            bin_q    <= 1'b0;
            borrow_q <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_q   <= a;
                        b_q   <= b;
                        bin_q <= 1'b0;
                        cnt_q <= '0;
                    end
                end
                SHIFT: begin
                    a_q   <= a_q >> 1;
                    b_q   <= b_q >> 1;
                    res_q <= {d, res_q[WIDTH-1:1]};
                    bin_q <= bout;
                    cnt_q <= cnt_q + CW'(1);
                    if (last) begin
                        diff_q   <= {d, res_q[WIDTH-1:1]};
                        borrow_q <= bout;
                    end
                end
                default: ;
            endcase
        end
    end

    assign diff   = diff_q;
    assign borrow = borrow_q;

`ifdef SUBR8U_DMR_EN
    logic d_dup, bout_dup, bin_dup_q, mism_q;

    fs1u u_fs_dup (
        .a    (a_q[0]),
        .b    (b_q[0]),
        .bin  (bin_dup_q),
        .d    (d_dup),
        .bout (bout_dup)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            bin_dup_q <= 1'b0;
            mism_q    <= 1'b0;
        end else if (state_q == IDLE && in_valid) begin
            bin_dup_q <= 1'b0;
            mism_q    <= 1'b0;
        end else if (state_q == SHIFT) begin
            bin_dup_q <= bout_dup;
            if ((d != d_dup) || (bout != bout_dup)) mism_q <= 1'b1;
        end
    end

    assign fault = out_valid & mism_q;
`else
    assign fault = 1'b0;
`endif

endmodule

// File: tb/tb_subr8u_serial.sv
// Self-checking bench for subr8u_serial against an arithmetic reference model.
// Define SUBR8U_DMR_EN to also exercise the duplicate-cell fault flag.
module tb_subr8u_serial;

    localparam int unsigned W = 8;
    localparam logic [W-1:0] MASK = '1;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] diff;
    logic         borrow;
    logic         fault;

    int checks = 0;
    int errors = 0;

    subr8u_serial #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .borrow    (borrow),
        .fault     (fault)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] model_diff(input int unsigned x, input int unsigned y);
        return W'((x + (1 << W) - y) % (1 << W));
    endfunction

    function automatic logic model_borrow(input int unsigned x, input int unsigned y);
        return x < y;
    endfunction

    // Present operands and wait for the accepting edge; leaves time at edge+1.
    task automatic accept_op(input logic [W-1:0] ta, input logic [W-1:0] tb_);
        bit acc = 0;
        bit rdy;
        in_valid = 1'b1;
        a = ta;
        b = tb_;
        for (int i = 0; i < 50 && !acc; i++) begin
            rdy = in_ready;
            @(posedge clk);
            #1;
            if (rdy) acc = 1;
        end
        in_valid = 1'b0;
        check("accept", 32'(acc), 32'd1);
    endtask

    // Full transaction with optional backpressure; junk drives in_valid while busy.
    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_,
                          input int hold, input bit junk, input logic exp_fault);
        int lat = 0;
        logic [W-1:0] ed;
        logic eb;
        ed = model_diff(ta, tb_);
        eb = model_borrow(ta, tb_);
        out_ready = 1'b0;
        accept_op(ta, tb_);
        if (junk) begin
            in_valid = 1'b1;
            a = ~ta;
            b = tb_ ^ 8'h5a;
        end
        while (!out_valid && lat < 100) begin
            check("in_ready_busy", 32'(in_ready), 32'd0);
            @(posedge clk);
            #1;
            lat++;
        end
        check("latency", lat, W);
        check("diff", 32'(diff), 32'(ed));
        check("borrow", 32'(borrow), 32'(eb));
        check("fault", 32'(fault), 32'(exp_fault));
        for (int h = 0; h < hold; h++) begin
            @(posedge clk);
            #1;
            check("hold_valid", 32'(out_valid), 32'd1);
            check("hold_ready", 32'(in_ready), 32'd0);
            check("hold_diff", 32'(diff), 32'(ed));
            check("hold_borrow", 32'(borrow), 32'(eb));
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        in_valid = 1'b0;
        check("valid_drop", 32'(out_valid), 32'd0);
        check("idle_ready", 32'(in_ready), 32'd1);
        check("diff_kept", 32'(diff), 32'(ed));
        check("fault_idle", 32'(fault), 32'd0);
    endtask

    logic [W-1:0] pa [16];
    logic [W-1:0] pb [16];
    logic [2*W-1:0] expq [$];

    initial begin
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_ready", 32'(in_ready), 32'd1);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_diff", 32'(diff), 32'd0);
        check("rst_borrow", 32'(borrow), 32'd0);
        check("rst_fault", 32'(fault), 32'd0);

        run_op(8'd200, 8'd55, 0, 0, 1'b0);
        run_op(8'd55, 8'd200, 0, 0, 1'b0);
        run_op(8'd0, 8'd1, 0, 0, 1'b0);
        run_op(8'd255, 8'd255, 0, 0, 1'b0);
        run_op(8'd100, 8'd37, 5, 1, 1'b0);
        for (int i = 0; i < 10; i++) begin
            run_op(W'($urandom), W'($urandom), int'($urandom_range(0, 2)), 0, 1'b0);
        end

        // Abort mid-shift: the previous result must be discarded by reset.
        run_op(8'd100, 8'd37, 0, 0, 1'b0);
        accept_op(8'd10, 8'd3);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("abort_valid", 32'(out_valid), 32'd0);
        check("abort_ready", 32'(in_ready), 32'd1);
        check("abort_diff", 32'(diff), 32'd0);
        repeat (12) begin
            @(posedge clk);
            #1;
            check("abort_no_result", 32'(out_valid), 32'd0);
        end
        run_op(8'd9, 8'd4, 0, 0, 1'b0);

        // Back-to-back stream with both handshakes held high.
        for (int i = 0; i < 16; i++) begin
            pa[i] = W'($urandom);
            pb[i] = W'($urandom);
        end
        begin
            int idx = 0;
            int nres = 0;
            int cyc = 0;
            int last_cyc = -1;
            bit rdy;
            logic [2*W-1:0] e;
            in_valid = 1'b1;
            a = pa[0];
            b = pb[0];
            out_ready = 1'b1;
            while (nres < 16 && cyc < 600) begin
                if (out_valid) begin
                    if (expq.size() > 0) begin
                        e = expq.pop_front();
                        check("b2b_diff", 32'(diff), 32'(model_diff(e[2*W-1:W], e[W-1:0])));
                        check("b2b_borrow", 32'(borrow),
                              32'(model_borrow(e[2*W-1:W], e[W-1:0])));
                    end else begin
                        check("b2b_unexpected", 32'd1, 32'd0);
                    end
                    if (last_cyc >= 0) check("b2b_spacing", cyc - last_cyc, W + 2);
                    last_cyc = cyc;
                    nres++;
                end
                rdy = in_ready;
                @(posedge clk);
                #1;
                cyc++;
                if (rdy && in_valid) begin
                    expq.push_back({a, b});
                    idx++;
                    if (idx < 16) begin
                        a = pa[idx];
                        b = pb[idx];
                    end else begin
                        in_valid = 1'b0;
                    end
                end
            end
            check("b2b_count", nres, 16);
            in_valid = 1'b0;
            out_ready = 1'b0;
        end
        @(posedge clk);
        #1;

`ifdef SUBR8U_DMR_EN
        // Inject a single-bit disagreement in the duplicate cell during bit 2.
        begin
            int lat = 0;
            accept_op(8'd0, 8'd0);
            repeat (2) @(posedge clk);
            #1;
            force dut.d_dup = 1'b1;
            @(posedge clk);
            #1;
            release dut.d_dup;
            while (!out_valid && lat < 100) begin
                @(posedge clk);
                #1;
                lat++;
            end
            check("dmr_valid", 32'(out_valid), 32'd1);
            check("dmr_diff", 32'(diff), 32'd0);
            check("dmr_fault", 32'(fault), 32'd1);
            out_ready = 1'b1;
            @(posedge clk);
            #1;
            out_ready = 1'b0;
            check("dmr_fault_idle", 32'(fault), 32'd0);
        end
        run_op(8'd77, 8'd12, 0, 0, 1'b0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
